switch_bounce_gen: RTL and testbench
====================================

// Module: switch_bounce_gen
// PURPOSE
//   Mechanical-switch emulator. Drives the noisy input that a switch debouncer
//   receives. A command sets a target level. The block then drives that level
//   with a programmable number of pseudo-random glitches, holds it stable, and
//   reports completion. Used in-fabric for self-test and by benches driving
//   debounced inputs.
// PARAMETERS
//   RESET_LEVEL  1'b0      switch_out value during and after reset
//   GLITCH_W     3         width of the random segment length; segment = 1..2**GLITCH_W cycles (GLITCH_W>=1)
//   HOLD_CYC     16        stable cycles after the last toggle before settled (>=1)
//   LFSR_SEED    16'hACE1  LFSR reset value; 16'h0000 is replaced by 16'h0001
// PORTS
//   clk          in   1  system clock, all logic on rising edge
//   reset        in   1  asynchronous, active-high reset
//   cmd_valid    in   1  command request
//   cmd_level    in   1  target switch level, sampled on accept
//   cmd_bounces  in   4  N = number of glitch pairs (0..15), sampled on accept
//   cmd_ready    out  1  high only in IDLE; accept = cmd_valid & cmd_ready
//   switch_out   out  1  emulated (bouncing) switch line, registered
//   busy         out  1  high in any state other than IDLE
//   settled      out  1  one-cycle pulse when the sequence completes
// BEHAVIOUR
//   Reset (async, immediate, also mid-sequence): state=IDLE, switch_out=RESET_LEVEL,
//     cmd_ready=1, busy=0, settled=0, lfsr=LFSR_SEED, all counters=0.
//   LFSR: 16-bit Galois, mask 16'hB400, shifts right every clock when not in reset.
//     seg_len = 1 + lfsr[GLITCH_W-1:0], using the value at the time of loading.
//   FSM states: IDLE, BOUNCE, HOLD.
//   IDLE: on accept at edge n, latch T=cmd_level and N=cmd_bounces.
//     If T != switch_out: switch_out<=T at edge n, toggles_left=2*N, load seg_len.
//       Next state is BOUNCE if N>0, else HOLD.
//     If T == switch_out: no toggles; next state is HOLD.
//     cmd_valid while not ready is ignored; the command is not queued.
//   BOUNCE: decrement the segment counter each cycle. On expiry: invert switch_out,
//     toggles_left--, reload seg_len. When toggles_left reaches 0, enter HOLD.
//     The last toggle always lands on T, because 2*N toggles is even.
//   HOLD: switch_out stays at T for exactly HOLD_CYC cycles after the last change.
//     Then state=IDLE and settled=1 for that first IDLE cycle. cmd_ready is also 1
//     in that cycle, so a back-to-back accept is legal.
//   Total switch_out transitions per command:
//     1+2N if T differs from the current level; 0 if T equals it.
//   busy = (state != IDLE); settled is never high while busy.
//   Widths: toggles_left is 5 bits (max 30); hold counter is clog2(HOLD_CYC+1) bits.
//     No counter wraps.
// TESTING
//   1 Reset with RESET_LEVEL=0 -> switch_out=0, cmd_ready=1, busy=0, settled=0.
//     Assert reset mid-BOUNCE -> same values in the same cycle.
//   2 Accept T=1, N=0 at edge n -> switch_out=1 from n; settled pulses at
//     edge n+HOLD_CYC (16); exactly 1 transition.
//   3 Accept T=1, N=3 -> exactly 7 transitions, final level 1, each glitch segment
//     1..8 cycles; segment lengths match a bench LFSR model seeded 16'hACE1.
//   4 Accept T=0 while switch_out=0, N=5 -> 0 transitions; settled HOLD_CYC cycles
//     after accept.
//   5 cmd_valid held high while busy -> no accept, no state change.
//     Accept in the settled cycle -> new sequence starts the next cycle.
//   6 Feed switch_out into a 10-stage all-ones debouncer with HOLD_CYC=16,
//     T=1, N=4 -> debouncer output rises before settled and stays high.

Source files
------------

// File: rtl/switch_bounce_gen.sv
// rtl/switch_bounce_gen.sv - mechanical switch emulator producing a bouncing level for debouncer stimulus
//
// Purpose: on an accepted command, drive switch_out to the target level with
// N pseudo-random glitch pairs, hold it stable for HOLD_CYC cycles, then pulse
// settled.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   cmd_valid    in   command request
//   cmd_level    in   target switch level, sampled on accept
//   cmd_bounces  in   number of glitch pairs (0..15), sampled on accept
//   cmd_ready    out  high only while idle
//   switch_out   out  emulated switch line (registered)
//   busy         out  high while a sequence is in progress
//   settled      out  one-cycle pulse on sequence completion
module switch_bounce_gen #(
    parameter logic        RESET_LEVEL = 1'b0,
    parameter int          GLITCH_W    = 3,
    parameter int          HOLD_CYC    = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_level,
    input  logic [3:0] cmd_bounces,
    output logic       cmd_ready,
    output logic       switch_out,
    output logic       busy,
    output logic       settled
);

    localparam int          SW        = GLITCH_W + 1;
    localparam int          HCW       = $clog2(HOLD_CYC + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYC - 1);
    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOUNCE,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic            sw_q, sw_d;
    logic            settled_q, settled_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [4:0]      toggles_q, toggles_d;
    logic [SW-1:0]   seg_q, seg_d;
    logic [HCW-1:0]  hold_q, hold_d;
    logic [SW-1:0]   seg_len;

    always_comb begin
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        seg_len   = SW'(lfsr_q[GLITCH_W-1:0]) + SW'(1);

        state_d   = state_q;
        sw_d      = sw_q;
        settled_d = 1'b0;
        toggles_d = toggles_q;
        seg_d     = seg_q;
        hold_d    = hold_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    hold_d = '0;
                    if (cmd_level != sw_q) begin
                        sw_d      = cmd_level;
                        toggles_d = {cmd_bounces, 1'b0};
                        seg_d     = seg_len;
                        state_d   = (cmd_bounces != 4'd0) ? S_BOUNCE : S_HOLD;
                    end else begin
                        state_d   = S_HOLD;
                    end
                end
            end
            S_BOUNCE: begin
                // seg_q holds the cycles remaining in the current segment;
                // a value of 1 means this edge ends it.
                if (seg_q == SW'(1)) begin
                    sw_d      = ~sw_q;
                    toggles_d = toggles_q - 5'd1;
                    seg_d     = seg_len;
                    if (toggles_q == 5'd1) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                    end
                end else begin
                    seg_d = seg_q - SW'(1);
                end
            end
            S_HOLD: begin
                // Entered on the edge of the last change, so HOLD_CYC edges
                // later the line has been stable for exactly HOLD_CYC cycles.
                if (hold_q == HOLD_LAST) begin
                    state_d   = S_IDLE;
                    settled_d = 1'b1;
                    hold_d    = '0;
                end else begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sw_q      <= RESET_LEVEL;
            settled_q <= 1'b0;
            lfsr_q    <= SEED_EFF;
            toggles_q <= '0;
            seg_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            sw_q      <= sw_d;
            settled_q <= settled_d;
            lfsr_q    <= lfsr_d;
            toggles_q <= toggles_d;
            seg_q     <= seg_d;
            hold_q    <= hold_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign switch_out = sw_q;
    assign settled    = settled_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// tb/tb_switch_bounce_gen.sv - directed self-checking bench for switch_bounce_gen
module tb_switch_bounce_gen;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_level;
    logic [3:0] cmd_bounces;
    logic       cmd_ready;
    logic       switch_out;
    logic       busy;
    logic       settled;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    logic [9:0]  db_sh;
    logic        db_out;
    int          db_rise_t;
    bit          db_fell;
    bit          settled_busy;

    switch_bounce_gen #(
        .RESET_LEVEL(1'b0),
        .GLITCH_W   (3),
        .HOLD_CYC   (16),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_level  (cmd_level),
        .cmd_bounces(cmd_bounces),
        .cmd_ready  (cmd_ready),
        .switch_out (switch_out),
        .busy       (busy),
        .settled    (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 10-stage debouncer: output high only after ten consecutive high samples
    always @(posedge clk or posedge reset) begin
        if (reset) db_sh <= '0;
        else       db_sh <= {db_sh[8:0], switch_out};
    end
    assign db_out = &db_sh;

    function automatic logic [15:0] lfsr_nxt(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // m_lfsr always equals the LFSR value the DUT uses at the next rising edge
    task automatic tick();
        @(posedge clk);
        m_lfsr = lfsr_nxt(m_lfsr);
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        m_lfsr = SEED;
    endtask

    // Ticks until settled is seen. Tick 0 is the edge where a presented
    // command is accepted; afterwards the command is dropped, or replaced by
    // (hl, hn) and kept valid when hold is set.
    task automatic watch(input bit hold, input logic hl, input logic [3:0] hn,
                         output int trans, output int settle_t, output int last_t);
        logic        prev;
        logic [15:0] l;
        int          exp_len;
        prev         = switch_out;
        trans        = 0;
        settle_t     = -1;
        last_t       = -1;
        exp_len      = 0;
        db_rise_t    = -1;
        db_fell      = 0;
        settled_busy = 0;
        for (int t = 0; t < 400 && settle_t < 0; t++) begin
            l = m_lfsr;
            tick();
            if (t == 0) begin
                if (hold) begin
                    cmd_level   = hl;
                    cmd_bounces = hn;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (switch_out !== prev) begin
                if (trans > 0) chk("seg_len", t - last_t, exp_len);
                trans++;
                last_t  = t;
                exp_len = 1 + int'(l[2:0]);
                prev    = switch_out;
            end
            if (db_out && db_rise_t < 0) db_rise_t = t;
            if (!db_out && db_rise_t >= 0) db_fell = 1;
            if (settled && busy) settled_busy = 1;
            if (settled) settle_t = t;
        end
        if (settle_t < 0) chk("settle_timeout", 0, 1);
        chk("settled_while_busy", settled_busy, 0);
    endtask

    int trans, settle_t, last_t;

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_level   = 1'b0;
        cmd_bounces = 4'd0;
        m_lfsr      = SEED;

        // reset values
        @(negedge clk);
        chk("rst_switch_out", switch_out, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_settled", settled, 0);
        release_reset();

        // T=1, N=0: single transition at accept, settled 16 edges later
        cmd_valid = 1'b1; cmd_level = 1'b1; cmd_bounces = 4'd0;
        watch(0, 1'b0, 4'd0, trans, settle_t, last_t);
        chk("n0_trans", trans, 1);
        chk("n0_change_edge", last_t, 0);
        chk("n0_settle_edge", settle_t, 16);
        chk("n0_level", switch_out, 1);
        chk("n0_ready_at_settle", cmd_ready, 1);

        // T=1, N=3 from level 0: seven transitions, LFSR-matched segments
        reset = 1'b1;
        release_reset();
        cmd_valid = 1'b1; cmd_level = 1'b1; cmd_bounces = 4'd3;
        watch(0, 1'b0, 4'd0, trans, settle_t, last_t);
        chk("n3_trans", trans, 7);
        chk("n3_level", switch_out, 1);
        chk("n3_hold", settle_t - last_t, 16);

        // reset asserted mid-BOUNCE takes effect immediately
        reset = 1'b1;
        release_reset();
        cmd_valid = 1'b1; cmd_level = 1'b1; cmd_bounces = 4'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_switch_out", switch_out, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_settled", settled, 0);
        release_reset();

        // T equals current level: no transitions, settled HOLD_CYC after accept
        cmd_valid = 1'b1; cmd_level = 1'b0; cmd_bounces = 4'd5;
        watch(0, 1'b0, 4'd0, trans, settle_t, last_t);
        chk("same_trans", trans, 0);
        chk("same_settle_edge", settle_t, 16);
        chk("same_level", switch_out, 0);

        // cmd_valid held while busy is ignored; accept in the settled cycle
        cmd_valid = 1'b1; cmd_level = 1'b1; cmd_bounces = 4'd1;
        watch(1, 1'b0, 4'd0, trans, settle_t, last_t);
        chk("hold_v_trans", trans, 3);
        chk("hold_v_level", switch_out, 1);
        chk("hold_v_hold", settle_t - last_t, 16);
        chk("b2b_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_switch_out", switch_out, 0);
        chk("b2b_busy", busy, 1);
        chk("b2b_settled", settled, 0);
        watch(0, 1'b0, 4'd0, trans, settle_t, last_t);
        chk("b2b_trans", trans, 0);
        chk("b2b_settle_edge", settle_t, 15);

        // debouncer sees a clean rise before settled, then stays high
        reset = 1'b1;
        release_reset();
        cmd_valid = 1'b1; cmd_level = 1'b1; cmd_bounces = 4'd4;
        watch(0, 1'b0, 4'd0, trans, settle_t, last_t);
        chk("db_trans", trans, 9);
        chk("db_rise_edge", db_rise_t, last_t + 10);
        chk("db_rise_before_settled", (db_rise_t >= 0 && db_rise_t < settle_t) ? 1 : 0, 1);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!db_out) db_fell = 1;
        end
        chk("db_stays_high", db_fell, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
